display_7seg_ctrl: RTL
======================

DISPLAY_7SEG_CTRL -- requirements
Module: display_7seg_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 100000, clocks per digit slot (legal 4..2^24).
REQ-003 SHALL have parameter BLANK_CYCLES, default 1000, anti-ghost blank clocks at the start of each slot (legal 1..DWELL_CYCLES-2).
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have en  input  1  level; 1 = scan, 0 = display dark.
REQ-007 SHALL have wr_en  input  1  one-cycle strobe writing wr_data into the pending digit buffer.
REQ-008 SHALL have wr_data  input  32  nibble k (bits 4k+3:4k) = hex value of digit k; bits above 4*NUM_DIGITS ignored.
REQ-009 SHALL have dp_wr_en  input  1  strobe writing dp_data into the pending decimal-point mask.
REQ-010 SHALL have dp_data  input  8  bit k = decimal point of digit k lit.
REQ-011 SHALL have an  output  NUM_DIGITS  active-low digit anodes.
REQ-012 SHALL have seg  output  7  active-low segments, bit order gfedcba.
REQ-013 SHALL have dp_n  output  1  active-low decimal point.
REQ-014 SHALL have frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-015 SHALL implement states IDLE, BLANK, DRIVE with slot counter cnt and digit index idx.
REQ-016 IDLE: an all 1, seg 7'h7F, dp_n 1, cnt 0, idx 0; exit to BLANK (cnt 0, idx 0) on first cycle en=1.
REQ-017 BLANK: an all 1, seg 7'h7F, dp_n 1; cnt increments; after BLANK_CYCLES cycles go to DRIVE.
REQ-018 DRIVE: an[idx]=0, others 1; seg = hex decode of active nibble idx; dp_n = ~active_dp[idx]; stays until cnt reaches DWELL_CYCLES-1, total slot length exactly DWELL_CYCLES.
REQ-019 At DRIVE end: cnt to 0, go to BLANK, idx increments; if idx = NUM_DIGITS-1 it wraps to 0 and frame_done pulses in that cycle.
REQ-020 Hex decode (active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 B=03 C=46 D=21 E=06 F=0E (hex).
REQ-021 an, seg, dp_n SHALL be registers; no combinational path from any input to any output.
REQ-022 wr_en/dp_wr_en update pending buffers only; active buffers load from pending (per buffer, only if its pending flag set, then flag cleared) at frame wrap and on IDLE->BLANK transition; no mid-frame tearing.
REQ-023 Write coincident with a load: active takes the old pending value; new value stored in pending, flag stays set.
REQ-024 Back-to-back writes within one frame: last write wins.
REQ-025 en=0 in any state: next cycle IDLE, outputs dark, frame_done not pulsed; pending buffers and flags preserved.
REQ-026 cnt SHALL be 24 bits minimum; idx ceil(log2(NUM_DIGITS)) bits, min 1.

Reset
REQ-027 rst SHALL force IDLE, cnt 0, idx 0, active and pending buffers 0, pending flags 0, an all 1, seg 7'h7F, dp_n 1, frame_done 0; rst overrides en and writes in the same cycle.
REQ-028 rst asserted mid-DRIVE SHALL darken outputs on the next edge.

Configuration
REQ-029 Macro DISP7_LEADING_ZERO_BLANK_EN: when defined, during DRIVE digit k>0 whose active nibble and all higher nibbles are 0 and whose dp bit is 0 SHALL show an all 1, seg 7'h7F, dp_n 1 (slot timing unchanged); digit 0 never suppressed.
REQ-030 Without DISP7_LEADING_ZERO_BLANK_EN every digit SHALL be driven per REQ-018.

Verification (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2)
REQ-031 rst, wr_en wr_data=32'h0000_1234, en=1 -> per 8-cycle slot 2 dark then 6 cycles an=1110 seg=19, then an=1101 seg=30, an=1011 seg=24, an=0111 seg=79; frame_done every 32 cycles.
REQ-032 wr_data=32'h0000_00AB mid-frame -> current frame unchanged; from next frame digit0 seg=03, digit1 seg=08.
REQ-033 dp_data=8'h04, wr_en same cycle as frame wrap -> dp_n=0 only in digit2 DRIVE; coincident digit value appears one frame later.
REQ-034 en dropped during DRIVE of digit 2 -> next cycle an=1111 seg=7F; re-enable restarts at digit 0 BLANK.
REQ-035 DISP7_LEADING_ZERO_BLANK_EN, wr_data=32'h0000_0007 -> digits 3..1 dark, digit0 seg=78; without macro digits 3..1 show seg=40.

Source files
------------

// File: rtl/display_7seg_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digits and decimal points.
// Optional leading-zero blanking: define DISP7_LEADING_ZERO_BLANK_EN.
module display_7seg_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  dp_wr_en,
  input  logic [7:0]            dp_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int CNT_W = 24;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_OFF;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h18;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  digits_t               act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_dig_vld_q, pend_dig_vld_d, pend_dp_vld_q, pend_dp_vld_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d, frame_done_q, frame_done_d;
  logic                  load, wrap, lz_blank;
  logic                  unused_hi;

  assign unused_hi = ^{wr_data, dp_data};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    wrap    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = S_BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
              load  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Active buffers take the old pending value; a coincident write re-arms pending.
  always_comb begin
    act_dig_d      = act_dig_q;
    act_dp_d       = act_dp_q;
    pend_dig_d     = pend_dig_q;
    pend_dp_d      = pend_dp_q;
    pend_dig_vld_d = pend_dig_vld_q;
    pend_dp_vld_d  = pend_dp_vld_q;
    if (load) begin
      if (pend_dig_vld_q) act_dig_d = pend_dig_q;
      if (pend_dp_vld_q)  act_dp_d  = pend_dp_q;
      pend_dig_vld_d = 1'b0;
      pend_dp_vld_d  = 1'b0;
    end
    if (wr_en) begin
      pend_dig_d     = wr_data[4*NUM_DIGITS-1:0];
      pend_dig_vld_d = 1'b1;
    end
    if (dp_wr_en) begin
      pend_dp_d     = dp_data[NUM_DIGITS-1:0];
      pend_dp_vld_d = 1'b1;
    end
  end

`ifdef DISP7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[k]: nibble k and every higher nibble are zero.
  always_comb begin
    zero_from                 = '0;
    zero_from[NUM_DIGITS-1]   = (act_dig_d[NUM_DIGITS-1] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (act_dig_d[k] == 4'h0);
    end
  end

  assign lz_blank = (idx_d != '0) && zero_from[idx_d] && !act_dp_d[idx_d];
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs are decoded from next-state values so the registers line up with the state.
  always_comb begin
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_n_d       = 1'b1;
    frame_done_d = wrap;
    if (state_d == S_DRIVE && !lz_blank) begin
      an_d   = ~(NUM_DIGITS'(1) << idx_d);
      seg_d  = hex7(act_dig_d[idx_d]);
      dp_n_d = ~act_dp_d[idx_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the digit buffers are reset too, since the display must never show stale data.
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      act_dig_q      <= '0;
      pend_dig_q     <= '0;
      act_dp_q       <= '0;
      pend_dp_q      <= '0;
      pend_dig_vld_q <= 1'b0;
      pend_dp_vld_q  <= 1'b0;
      an_q           <= '1;
      seg_q          <= SEG_OFF;
      dp_n_q         <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      act_dig_q      <= act_dig_d;
      pend_dig_q     <= pend_dig_d;
      act_dp_q       <= act_dp_d;
      pend_dp_q      <= pend_dp_d;
      pend_dig_vld_q <= pend_dig_vld_d;
      pend_dp_vld_q  <= pend_dp_vld_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_n_q         <= dp_n_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule
